nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit passes; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  W  first operand.
REQ-006 SHALL have port op_b  input  W  second operand.
REQ-007 SHALL have port cin  input  1  carry into nibble 0.
REQ-008 SHALL have port add_a  output  4  nibble of op_a driven to the external 4-bit adder.
REQ-009 SHALL have port add_b  output  4  nibble of op_b driven to the external 4-bit adder.
REQ-010 SHALL have port add_ci  output  1  carry driven to the external adder.
REQ-011 SHALL have port add_s  input  4  sum returned combinationally by the external adder, same cycle.
REQ-012 SHALL have port add_co  input  1  carry-out returned combinationally by the external adder, same cycle.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-015 SHALL have port sum  output  W  assembled result.
REQ-016 SHALL have port cout  output  1  final carry-out.
REQ-017 SHALL have port ovf  output  1  two's-complement overflow of the W-bit add.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL, in IDLE with start=1 at an edge, latch op_a, op_b and cin into internal registers, clear nibble index k to 0, and enter RUN.
REQ-020 SHALL ignore start in RUN and DONE; latched operands are not altered by input changes after acceptance.
REQ-021 SHALL, in RUN, drive add_a = latched op_a[4k+3:4k], add_b = latched op_b[4k+3:4k], add_ci = latched cin when k=0, else the registered carry from pass k-1.
REQ-022 SHALL, at each RUN edge, store add_s into internal result nibble k, store add_co into the carry register, and increment k.
REQ-023 SHALL move RUN -> DONE at the edge completing k = NIBBLES-1; k does not wrap within one operation.
REQ-024 SHALL, in DONE, assert done=1 for exactly one cycle and return to IDLE at the next edge.
REQ-025 SHALL update sum, cout and ovf on the RUN->DONE edge and hold them until the edge ending the next operation's RUN.
REQ-026 SHALL compute ovf = (op_a[W-1] == op_b[W-1]) and (sum[W-1] != op_a[W-1]), using latched operands.
REQ-027 SHALL drive add_a, add_b, add_ci to 0 in IDLE and DONE.
REQ-028 SHALL give a latency from the accepting edge to done high of NIBBLES+1 edges; the next start is accepted no earlier than the first IDLE cycle after DONE.

Reset
REQ-029 SHALL, when rst_n=0 at an edge, enter IDLE and clear busy, done, sum, cout, ovf, k, the carry register and the latched operands to 0.
REQ-030 SHALL abort an operation in progress on reset; no done pulse follows, and outputs read 0.
REQ-031 SHALL give reset priority over start at the same edge.

Verification
REQ-032 SHALL check op_a=0x1234, op_b=0x0000, cin=0 -> add_a sequence 4,3,2,1 over four RUN cycles; sum=0x1234, cout=0, ovf=0.
REQ-033 SHALL check 0x00FF + 0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0; add_ci sequence 0,1,1,0; done on the 5th edge after start.
REQ-034 SHALL check 0xFFFF + 0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
REQ-035 SHALL check 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-036 SHALL check that start pulsed with new operands in RUN is ignored and the original result completes, and that start held high continuously yields back-to-back operations spaced NIBBLES+2 cycles apart.
REQ-037 SHALL check rst_n=0 for one cycle during RUN at k=2 -> IDLE next cycle, busy=0, sum=0, no done pulse; the next start then completes normally.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Sequences a W-bit addition (W = 4*NIBBLES) through an external combinational
//   4-bit adder, one nibble per clock, least-significant nibble first.
//
// Ports
//   clk     in   clock, all state changes on rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request a new addition (sampled only when idle)
//   op_a    in   W-bit first operand
//   op_b    in   W-bit second operand
//   cin     in   carry into nibble 0
//   add_a   out  op_a nibble presented to the external adder
//   add_b   out  op_b nibble presented to the external adder
//   add_ci  out  carry presented to the external adder
//   add_s   in   4-bit sum from the external adder (same cycle)
//   add_co  in   carry-out from the external adder (same cycle)
//   busy    out  high while running and during the done cycle
//   done    out  one-cycle pulse, result valid
//   sum     out  assembled W-bit result
//   cout    out  final carry-out
//   ovf     out  two's-complement overflow of the W-bit add

module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_ci,
    input  logic [3:0]             add_s,
    input  logic                   add_co,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int unsigned W  = 4 * NIBBLES;
    // Wide enough to hold NIBBLES so the index never wraps after the last pass.
    localparam int unsigned KW = $clog2(NIBBLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q;
    logic [W-1:0]  a_q, b_q;
    logic          cin_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [3:0]    sel_a, sel_b;
    logic [W-1:0]  res_d;
    logic          carry_in;
    logic          last;
    logic          ovf_d;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        res_d = res_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                sel_a            = a_q[4*i +: 4];
                sel_b            = b_q[4*i +: 4];
                res_d[4*i +: 4]  = add_s;
            end
        end
        last     = (k_q == KW'(NIBBLES - 1));
        carry_in = (k_q == '0) ? cin_q : carry_q;
        // res_d already holds the final nibble on the last pass
        ovf_d    = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        cin_q   <= cin;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= add_co;
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        state_q <= DONE;
                        sum_q   <= res_d;
                        cout_q  <= add_co;
                        ovf_q   <= ovf_d;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        if (state_q == RUN) begin
            add_a  = sel_a;
            add_b  = sel_b;
            add_ci = carry_in;
        end
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
